// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared FSM encoding, requester ids and perf counter helpers for data_mem_arbiter.
package data_mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;
  localparam int PERF_W = 16;
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] c, input logic en);
    return (en && c != '1) ? c + 1'b1 : c;
  endfunction
endpackage

// File: rtl/data_mem_arb_rr_pick.sv
// data_mem_arb_rr_pick: combinational 2-way round-robin picker.
module data_mem_arb_rr_pick
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id    = (&req) ? ~last_grant : (req[1] ? REQ_DBG : REQ_CPU);
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter/sequencer for the single data memory port.
// Optional perf counters under DATA_MEM_ARBITER_PERF_EN.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int   AW        = 32,
  parameter int   DW        = 32,
  parameter logic INIT_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_sign_mask,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_sign_mask,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [3:0]    mem_sign_mask,
  input  logic [DW-1:0] mem_rdata,
`ifdef DATA_MEM_ARBITER_PERF_EN
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_m0_cnt,
  output logic [PERF_W-1:0] perf_m1_cnt,
  output logic [PERF_W-1:0] perf_conflict_cnt,
`endif
  output logic          busy
);
  state_t        state;
  logic          last_grant, gid, gwe, gnt_valid, gnt_id, sel_we;
  logic [DW-1:0] rd;
  data_mem_arb_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );
  always_comb begin
    sel_we = (gnt_id == REQ_DBG) ? m1_we : m0_we;
    rd     = gwe ? '0 : mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= INIT_LAST;
      gid           <= REQ_CPU;
      gwe           <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_sign_mask <= '0;
      m0_ack        <= 1'b0;
      m1_ack        <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
      busy          <= 1'b0;
    end else begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      case (state)
        IDLE: if (gnt_valid) begin
          state         <= ISSUE;
          busy          <= 1'b1;
          gid           <= gnt_id;
          gwe           <= sel_we;
          last_grant    <= gnt_id;
          mem_addr      <= (gnt_id == REQ_DBG) ? m1_addr : m0_addr;
          mem_wdata     <= (gnt_id == REQ_DBG) ? m1_wdata : m0_wdata;
          mem_sign_mask <= (gnt_id == REQ_DBG) ? m1_sign_mask : m0_sign_mask;
          mem_read      <= ~sel_we;
          mem_write     <= sel_we;
        end
        ISSUE: begin
          state     <= WAIT;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
        WAIT: state <= RESP;
        RESP: begin
          // memory data is valid now; ack lands in the following IDLE cycle
          state    <= IDLE;
          busy     <= 1'b0;
          m0_ack   <= (gid == REQ_CPU);
          m1_ack   <= (gid == REQ_DBG);
          m0_rdata <= (gid == REQ_CPU) ? rd : '0;
          m1_rdata <= (gid == REQ_DBG) ? rd : '0;
        end
      endcase
    end
  end
`ifdef DATA_MEM_ARBITER_PERF_EN
  logic issue_en;
  always_comb issue_en = (state == IDLE) && gnt_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_m0_cnt       <= '0;
      perf_m1_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else if (perf_clr) begin
      perf_m0_cnt       <= '0;
      perf_m1_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      perf_m0_cnt       <= sat_inc(perf_m0_cnt, issue_en && gnt_id == REQ_CPU);
      perf_m1_cnt       <= sat_inc(perf_m1_cnt, issue_en && gnt_id == REQ_DBG);
      perf_conflict_cnt <= sat_inc(perf_conflict_cnt, state == IDLE && m0_req && m1_req);
    end
  end
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random checks of data_mem_arbiter against a transaction-level model.
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rq [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic [3:0]  rs [2];
  logic        m0_ack, m1_ack, mem_read, mem_write, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem [64] = '{1: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] ref_mem [64] = '{1: 32'hDEADBEEF, default: 32'h0};
  int          e = 0, s = -100, free = 0, mode = 0, total = 0, passed = 0;
  logic        last = 1'b1, who = 1'b0, wes = 1'b0;
  logic [31:0] as_ = '0, ds = '0, xr = '0;
  logic [3:0]  ss = '0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(rq[0]), .m0_we(rw[0]), .m0_addr(ra[0]), .m0_wdata(rd[0]), .m0_sign_mask(rs[0]),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(rq[1]), .m1_we(rw[1]), .m1_addr(ra[1]), .m1_wdata(rd[1]), .m1_sign_mask(rs[1]),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_sign_mask(mem_sign_mask), .mem_rdata(mem_rdata), .busy(busy)
  );

  // memory: samples the strobe at the end of ISSUE, data held through RESP
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic put(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    rq[i] = 1'b1;
    rw[i] = we;
    ra[i] = a;
    rd[i] = d;
    rs[i] = 4'h2;
  endtask

  task automatic newreq(input int i);
    put(i, 1'($urandom_range(1)), 32'h1000 + {26'b0, 4'($urandom_range(15)), 2'b0}, $urandom);
    rs[i] = 4'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    if (e >= free && (rq[0] || rq[1])) begin
      who  = (rq[0] && rq[1]) ? ~last : rq[1];
      last = who;
      s    = e;
      free = e + 4;
      wes  = rw[who];
      as_  = ra[who];
      ds   = rd[who];
      ss   = rs[who];
      if (wes) begin
        ref_mem[as_[7:2]] = ds;
        xr = '0;
      end else xr = ref_mem[as_[7:2]];
    end
    @(negedge clk);
    chk("busy", {31'b0, busy}, {31'b0, e >= s && e <= s + 2});
    chk("m0_ack", {31'b0, m0_ack}, {31'b0, e == s + 3 && !who});
    chk("m1_ack", {31'b0, m1_ack}, {31'b0, e == s + 3 && who});
    chk("mem_read", {31'b0, mem_read}, {31'b0, e == s && !wes});
    chk("mem_write", {31'b0, mem_write}, {31'b0, e == s && wes});
    if (e == s) begin
      chk("mem_addr", mem_addr, as_);
      chk("mem_wdata", mem_wdata, ds);
      chk("mem_sign_mask", {28'b0, mem_sign_mask}, {28'b0, ss});
    end
    if (e == s + 3) chk(who ? "m1_rdata" : "m0_rdata", who ? m1_rdata : m0_rdata, xr);
    for (int i = 0; i < 2; i++) begin
      if (e == s + 3 && who == 1'(i)) begin
        if (mode == 0) rq[i] = 1'b0;
        else if (mode == 2) begin
          if ($urandom_range(1) == 1) newreq(i);
          else rq[i] = 1'b0;
        end
      end else if (mode == 2 && !rq[i] && $urandom_range(2) == 0) newreq(i);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "busy"}, {31'b0, busy}, 32'h0);
    chk({p, "m0_ack"}, {31'b0, m0_ack}, 32'h0);
    chk({p, "m1_ack"}, {31'b0, m1_ack}, 32'h0);
    chk({p, "m0_rdata"}, m0_rdata, 32'h0);
    chk({p, "m1_rdata"}, m1_rdata, 32'h0);
    chk({p, "mem_read"}, {31'b0, mem_read}, 32'h0);
    chk({p, "mem_write"}, {31'b0, mem_write}, 32'h0);
    chk({p, "mem_addr"}, mem_addr, 32'h0);
    chk({p, "mem_wdata"}, mem_wdata, 32'h0);
    chk({p, "mem_sign_mask"}, {28'b0, mem_sign_mask}, 32'h0);
  endtask

  task automatic end_reset();
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s     = -100;
    free  = 0;
    last  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0;
      rw[i] = 1'b0;
      ra[i] = '0;
      rd[i] = '0;
      rs[i] = '0;
    end
    #12;
    chk_zero("reset_");
    end_reset();
    // single CPU read
    mode = 0;
    put(0, 1'b0, 32'h1004, 32'h0);
    repeat (6) step();
    // debug write then read back
    put(1, 1'b1, 32'h1008, 32'h12345678);
    repeat (5) step();
    put(1, 1'b0, 32'h1008, 32'h0);
    repeat (5) step();
    // both held from reset: strict alternation 0,1,0,1
    rst_n = 1'b0;
    end_reset();
    mode = 1;
    put(0, 1'b0, 32'h1004, 32'h0);
    put(1, 1'b0, 32'h1008, 32'h0);
    repeat (16) step();
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    mode = 0;
    repeat (2) step();
    // reset during WAIT
    put(0, 1'b0, 32'h1004, 32'h0);
    repeat (2) step();
    chk("in_wait", {31'b0, e == s + 1}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst_");
    end_reset();
    repeat (3) step();
    put(0, 1'b0, 32'h1004, 32'h0);
    repeat (5) step();
    // LED write
    put(0, 1'b1, 32'h2000, 32'h5A);
    repeat (5) step();
    chk("led_reg", mem[0], 32'h5A);
    // random traffic
    mode = 2;
    repeat (400) step();
    mode = 0;
    repeat (8) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
